// File: rtl/dfh_chain_walker.sv
// dfh_chain_walker: walks a Device Feature Header linked list with 64-bit MMIO reads, one record per DFH.
// Define DFH_WALKER_TIMEOUT_EN to build the read-response timeout (err_code 4).
module dfh_chain_walker #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned MAX_DFH     = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned IDX_W      = $clog2(MAX_DFH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [63:0]       rd_rsp_data,
    output logic              dfh_valid,
    input  logic              dfh_ready,
    output logic [ADDR_W-1:0] dfh_addr,
    output logic [63:0]       dfh_data,
    output logic [IDX_W-1:0]  dfh_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [IDX_W-1:0]  dfh_count
);
    localparam int unsigned OFF_W = 24;
    localparam int unsigned SUM_W = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ZERO_OFF = 3'd1,
        ERR_OVERFLOW = 3'd2,
        ERR_MAX_DFH  = 3'd3,
        ERR_TIMEOUT  = 3'd4
    } err_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [63:0]       data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_e              err_code_q, err_code_d;

    logic [OFF_W-1:0]  nxt_off;
    logic              eol;
    logic [SUM_W-1:0]  sum;
    logic              overflow;
    logic              last_idx;

`ifdef DFH_WALKER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_expire;

    always_comb tmo_expire = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    always_comb unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    // Any carry out of ADDR_W (including offset bits above ADDR_W) is an overflow.
    always_comb begin
        nxt_off  = data_q[39:16];
        eol      = data_q[40];
        sum      = SUM_W'(cur_addr_q) + SUM_W'(nxt_off);
        overflow = |sum[SUM_W-1:ADDR_W];
        last_idx = ((32'(idx_q) + 32'd1) == MAX_DFH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        count_d    = count_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
`ifdef DFH_WALKER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    count_d    = '0;
                    idx_d      = '0;
                    cur_addr_d = {base_addr[ADDR_W-1:3], 3'b000};
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_req_ready) begin
                    state_d = S_WAIT;
`ifdef DFH_WALKER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_WAIT: begin
                // A response landing on the expiry cycle takes priority over the timeout.
                if (rd_rsp_valid) begin
                    data_d  = rd_rsp_data;
                    state_d = S_EMIT;
                end
`ifdef DFH_WALKER_TIMEOUT_EN
                else if (tmo_expire) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            S_EMIT: begin
                if (dfh_ready) begin
                    count_d = count_q + IDX_W'(1);
                    if (eol) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (nxt_off == '0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ZERO_OFF;
                        state_d    = S_ERR;
                    end else if (overflow) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                        state_d    = S_ERR;
                    end else if (last_idx) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MAX_DFH;
                        state_d    = S_ERR;
                    end else begin
                        cur_addr_d = sum[ADDR_W-1:0];
                        idx_d      = idx_q + IDX_W'(1);
                        state_d    = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_req_valid = (state_q == S_REQ);
        dfh_valid    = (state_q == S_EMIT);
        busy         = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_EMIT);
        rd_req_addr  = {cur_addr_q[ADDR_W-1:3], 3'b000};
        dfh_addr     = cur_addr_q;
        dfh_data     = data_q;
        dfh_idx      = idx_q;
        done         = done_q;
        err          = err_q;
        err_code     = err_code_q;
        dfh_count    = count_q;
    end

endmodule

// File: tb/tb_dfh_chain_walker.sv
// Directed bench for dfh_chain_walker: memory-backed read responder and stallable record consumer.
`timescale 1ns/1ps
module tb_dfh_chain_walker;
    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned MAX_DFH     = 4;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned IDX_W       = $clog2(MAX_DFH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic [63:0]       rd_rsp_data;
    logic              dfh_valid;
    logic              dfh_ready;
    logic [ADDR_W-1:0] dfh_addr;
    logic [63:0]       dfh_data;
    logic [IDX_W-1:0]  dfh_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [IDX_W-1:0]  dfh_count;

    always #5 clk = ~clk;

    dfh_chain_walker #(
        .ADDR_W      (ADDR_W),
        .MAX_DFH     (MAX_DFH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .dfh_valid    (dfh_valid),
        .dfh_ready    (dfh_ready),
        .dfh_addr     (dfh_addr),
        .dfh_data     (dfh_data),
        .dfh_idx      (dfh_idx),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .dfh_count    (dfh_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]       mem [int unsigned];
    int                rsp_lat   = 1;
    int                req_stall = 0;
    int                rec_stall = 0;
    bit                rsp_en    = 1'b1;
    int                lat_cnt   = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                addr_bad  = 0;
    int                rec_bad   = 0;

    logic [ADDR_W-1:0] read_log [$];
    logic [ADDR_W-1:0] rec_addr [$];
    logic [63:0]       rec_data [$];
    logic [IDX_W-1:0]  rec_idx  [$];

    int                req_stall_cnt = 0;
    logic [ADDR_W-1:0] hold_req_addr = '0;
    int                rec_stall_cnt = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [63:0]       hold_data = '0;
    logic [IDX_W-1:0]  hold_idx  = '0;

    function automatic logic [63:0] mk_dfh(input bit eol, input logic [23:0] nxt, input logic [15:0] id);
        return {23'd0, eol, nxt, id};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [ADDR_W-1:0] a);
        int unsigned k;
        k = 32'(a);
        if (mem.exists(k)) return mem[k];
        return '0;
    endfunction

    // Read responder: raises rd_req_ready after req_stall cycles, answers rsp_lat cycles later.
    initial begin : responder
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            rd_rsp_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0 && rsp_en) begin
                    rd_rsp_valid = 1'b1;
                    rd_rsp_data  = mem_rd(pend_addr);
                end
            end
            if (!rst_n) begin
                rd_req_ready  = 1'b0;
                req_stall_cnt = 0;
            end else if (rd_req_ready) begin
                rd_req_ready = 1'b0;
            end else if (rd_req_valid) begin
                if (req_stall_cnt > 0 && rd_req_addr !== hold_req_addr) addr_bad++;
                hold_req_addr = rd_req_addr;
                if (req_stall_cnt < req_stall) begin
                    req_stall_cnt++;
                end else begin
                    rd_req_ready  = 1'b1;
                    req_stall_cnt = 0;
                    read_log.push_back(rd_req_addr);
                    pend_addr = rd_req_addr;
                    lat_cnt   = rsp_lat;
                end
            end
        end
    end

    // Record consumer: holds dfh_ready low rec_stall cycles per record.
    initial begin : consumer
        dfh_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dfh_ready     = 1'b0;
                rec_stall_cnt = 0;
            end else if (dfh_ready) begin
                dfh_ready = 1'b0;
            end else if (dfh_valid) begin
                if (rec_stall_cnt > 0 &&
                    (dfh_addr !== hold_addr || dfh_data !== hold_data || dfh_idx !== hold_idx)) rec_bad++;
                hold_addr = dfh_addr;
                hold_data = dfh_data;
                hold_idx  = dfh_idx;
                if (rec_stall_cnt < rec_stall) begin
                    rec_stall_cnt++;
                end else begin
                    dfh_ready     = 1'b1;
                    rec_stall_cnt = 0;
                    rec_addr.push_back(dfh_addr);
                    rec_data.push_back(dfh_data);
                    rec_idx.push_back(dfh_idx);
                end
            end
        end
    end

    task automatic clear_logs();
        read_log.delete();
        rec_addr.delete();
        rec_data.delete();
        rec_idx.delete();
        addr_bad = 0;
        rec_bad  = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        lat_cnt   = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic kick(input logic [ADDR_W-1:0] b);
        @(negedge clk);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = '1;
    endtask

    task automatic wait_end(input int max_cyc, output int cyc);
        cyc = 0;
        while (!(done || err) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!(done || err)) begin
            n_fail++;
            $display("FAIL walk_end_bound: done=%0b err=%0b after %0d cycles, required done or err", done, err, cyc);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rd_req_valid, rd_req_addr, dfh_valid, dfh_addr, dfh_data, dfh_idx,
             busy, done, err, err_code, dfh_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b code=%0d cnt=%0d rdv=%0b dv=%0b data=%h, required all 0",
                     busy, done, err, err_code, dfh_count, rd_req_valid, dfh_valid, dfh_data);
        end
    endtask

    task automatic load_basic_chain();
        mem.delete();
        mem[32'h0000] = mk_dfh(1'b0, 24'h001000, 16'h00A0);
        mem[32'h1000] = mk_dfh(1'b0, 24'h002000, 16'h00A1);
        mem[32'h3000] = mk_dfh(1'b1, 24'h000000, 16'h00A2);
    endtask

    task automatic check_basic_records(input string tag);
        logic [ADDR_W-1:0] ea [3];
        logic [ADDR_W-1:0] a;
        logic [63:0]       d;
        logic [IDX_W-1:0]  x;
        ea[0] = 20'h00000;
        ea[1] = 20'h01000;
        ea[2] = 20'h03000;
        n_checks++;
        if (rec_addr.size() != 3) begin
            n_fail++;
            $display("FAIL %s_rec_count: got %0d records, required 3", tag, rec_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            a = (i < rec_addr.size()) ? rec_addr[i] : 'x;
            d = (i < rec_data.size()) ? rec_data[i] : 'x;
            x = (i < rec_idx.size())  ? rec_idx[i]  : 'x;
            n_checks++;
            if (a !== ea[i] || x !== IDX_W'(i) || d !== mem_rd(ea[i])) begin
                n_fail++;
                $display("FAIL %s_rec%0d: got addr=%h idx=%0d data=%h, required addr=%h idx=%0d data=%h",
                         tag, i, a, x, d, ea[i], i, mem_rd(ea[i]));
            end
        end
        n_checks++;
        if (read_log.size() != 3) begin
            n_fail++;
            $display("FAIL %s_reads: got %0d reads, required 3", tag, read_log.size());
        end
        n_checks++;
        if ({done, err, err_code, dfh_count, busy} !== {1'b1, 1'b0, 3'd0, IDX_W'(3), 1'b0}) begin
            n_fail++;
            $display("FAIL %s_status: got done=%0b err=%0b code=%0d cnt=%0d busy=%0b, required 1 0 0 3 0",
                     tag, done, err, err_code, dfh_count, busy);
        end
    endtask

    task automatic test_basic_chain();
        int cyc;
        load_basic_chain();
        clear_logs();
        rsp_lat = 1; req_stall = 0; rec_stall = 0;
        kick(20'h00000);
        wait_end(300, cyc);
        check_basic_records("basic");
        // 3 cycles per record with single-cycle response and no stalls
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL basic_latency: walk took %0d cycles, required 9", cyc);
        end
    endtask

    task automatic test_stall();
        int cyc;
        load_basic_chain();
        clear_logs();
        rsp_lat = 2; req_stall = 3; rec_stall = 5;
        kick(20'h00000);
        wait_end(400, cyc);
        check_basic_records("stall");
        n_checks++;
        if (addr_bad != 0 || rec_bad != 0) begin
            n_fail++;
            $display("FAIL stall_stability: req_addr changes=%0d record changes=%0d, required 0 and 0", addr_bad, rec_bad);
        end
        rsp_lat = 1; req_stall = 0; rec_stall = 0;
    endtask

    task automatic test_zero_offset();
        int cyc;
        mem.delete();
        mem[32'h40] = mk_dfh(1'b0, 24'h000000, 16'h0040);
        clear_logs();
        kick(20'h00045);
        wait_end(300, cyc);
        n_checks++;
        if (rec_addr.size() != 1 || read_log.size() != 1) begin
            n_fail++;
            $display("FAIL zero_off_count: got %0d records %0d reads, required 1 and 1", rec_addr.size(), read_log.size());
        end
        n_checks++;
        if (rec_addr.size() > 0 && (rec_addr[0] !== 20'h00040 || rec_data[0] !== mk_dfh(1'b0, 24'h0, 16'h0040))) begin
            n_fail++;
            $display("FAIL zero_off_rec: got addr=%h data=%h, required addr=00040 data=%h",
                     rec_addr[0], rec_data[0], mk_dfh(1'b0, 24'h0, 16'h0040));
        end
        n_checks++;
        if ({err, err_code, done, busy, dfh_count} !== {1'b1, 3'd1, 1'b0, 1'b0, IDX_W'(1)}) begin
            n_fail++;
            $display("FAIL zero_off_status: got err=%0b code=%0d done=%0b busy=%0b cnt=%0d, required 1 1 0 0 1",
                     err, err_code, done, busy, dfh_count);
        end
    endtask

    task automatic test_max_dfh();
        int cyc;
        mem.delete();
        for (int i = 0; i < 5; i++) mem[32'(i) * 32'h100] = mk_dfh(1'b0, 24'h000100, 16'(16'h0B0 + i));
        clear_logs();
        kick(20'h00000);
        wait_end(300, cyc);
        n_checks++;
        if (rec_addr.size() != 4 || read_log.size() != 4) begin
            n_fail++;
            $display("FAIL max_dfh_count: got %0d records %0d reads, required 4 and 4", rec_addr.size(), read_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= rec_addr.size() || rec_addr[i] !== ADDR_W'(i * 32'h100) || rec_idx[i] !== IDX_W'(i)) begin
                n_fail++;
                $display("FAIL max_dfh_rec%0d: record missing or wrong addr/idx, required addr=%h idx=%0d", i, ADDR_W'(i * 32'h100), i);
            end
        end
        n_checks++;
        if ({err, err_code, done, dfh_count} !== {1'b1, 3'd3, 1'b0, IDX_W'(4)}) begin
            n_fail++;
            $display("FAIL max_dfh_status: got err=%0b code=%0d done=%0b cnt=%0d, required 1 3 0 4", err, err_code, done, dfh_count);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        mem.delete();
        mem[32'hFF000] = mk_dfh(1'b0, 24'h000FF8, 16'h00C0);
        mem[32'hFFFF8] = mk_dfh(1'b0, 24'h000008, 16'h00C1);
        clear_logs();
        kick(20'hFF000);
        wait_end(300, cyc);
        n_checks++;
        if (rec_addr.size() != 2 || read_log.size() != 2) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d records %0d reads, required 2 and 2", rec_addr.size(), read_log.size());
        end
        n_checks++;
        if (read_log.size() == 2 && read_log[1] !== 20'hFFFF8) begin
            n_fail++;
            $display("FAIL ovf_last_read: got %h, required FFFF8", read_log[1]);
        end
        n_checks++;
        if ({err, err_code, done, dfh_count} !== {1'b1, 3'd2, 1'b0, IDX_W'(2)}) begin
            n_fail++;
            $display("FAIL ovf_status: got err=%0b code=%0d done=%0b cnt=%0d, required 1 2 0 2", err, err_code, done, dfh_count);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        mem.delete();
        mem[32'h0] = mk_dfh(1'b1, 24'h0, 16'h00D0);
        clear_logs();
`ifdef DFH_WALKER_TIMEOUT_EN
        rsp_en = 1'b0;
        kick(20'h00000);
        wait_end(100, cyc);
        n_checks++;
        if (cyc != 17) begin
            n_fail++;
            $display("FAIL tmo_latency: err after %0d cycles from start, required 17 (16 in WAIT)", cyc);
        end
        n_checks++;
        if ({err, err_code, done, busy, dfh_count} !== {1'b1, 3'd4, 1'b0, 1'b0, IDX_W'(0)} || rec_addr.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_status: got err=%0b code=%0d done=%0b busy=%0b cnt=%0d recs=%0d, required 1 4 0 0 0 0",
                     err, err_code, done, busy, dfh_count, rec_addr.size());
        end
        rsp_en  = 1'b1;
        rsp_lat = 16;
        clear_logs();
        kick(20'h00000);
        wait_end(100, cyc);
        n_checks++;
        if ({done, err, err_code} !== {1'b1, 1'b0, 3'd0} || rec_addr.size() != 1) begin
            n_fail++;
            $display("FAIL tmo_race: got done=%0b err=%0b code=%0d recs=%0d, required 1 0 0 1", done, err, err_code, rec_addr.size());
        end
        rsp_lat = 1;
`else
        rsp_en = 1'b0;
        kick(20'h00000);
        repeat (40) @(negedge clk);
        n_checks++;
        if ({busy, err, done, rd_req_valid, dfh_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL wait_hold: got busy=%0b err=%0b done=%0b rdv=%0b dv=%0b, required 1 0 0 0 0",
                     busy, err, done, rd_req_valid, dfh_valid);
        end
        rsp_en = 1'b1;
        cyc = 0;
`endif
        do_reset();
    endtask

    task automatic test_reset_mid_walk();
        int cyc;
        int guard;
        load_basic_chain();
        clear_logs();
        rsp_lat = 6;
        kick(20'h00000);
        guard = 0;
        while (rec_addr.size() < 2 && guard < 200) begin @(negedge clk); guard++; end
        while (!(busy && !rd_req_valid && !dfh_valid) && guard < 200) begin @(negedge clk); guard++; end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL midrst_reach_wait: third WAIT not reached in %0d cycles, required under 200", guard);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, rd_req_valid, dfh_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_async: got busy=%0b rdv=%0b dv=%0b during reset, required 0 0 0", busy, rd_req_valid, dfh_valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if ({rd_req_valid, rd_req_addr, dfh_valid, dfh_addr, dfh_data, dfh_idx,
             busy, done, err, err_code, dfh_count} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy=%0b done=%0b err=%0b cnt=%0d dv=%0b data=%h, required all 0",
                     busy, done, err, dfh_count, dfh_valid, dfh_data);
        end
        n_checks++;
        if (rec_addr.size() != 2 || read_log.size() != 3) begin
            n_fail++;
            $display("FAIL midrst_traffic: got %0d records %0d reads, required 2 and 3", rec_addr.size(), read_log.size());
        end
        rsp_lat = 1;
        clear_logs();
        kick(20'h00000);
        wait_end(300, cyc);
        n_checks++;
        if (rec_addr.size() < 1 || rec_addr[0] !== 20'h0 || rec_idx[0] !== '0 || rec_data[0] !== mk_dfh(1'b0, 24'h001000, 16'h00A0)) begin
            n_fail++;
            $display("FAIL midrst_restart: first record missing or wrong (recs=%0d), required addr=0 idx=0 data=%h",
                     rec_addr.size(), mk_dfh(1'b0, 24'h001000, 16'h00A0));
        end
    endtask

    initial begin : main
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        do_reset();
        test_reset();
        test_basic_chain();
        test_stall();
        test_zero_offset();
        test_max_dfh();
        test_overflow();
        test_timeout();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dfh_chain_walker.md
Name: dfh_chain_walker

Overview:
- Hardware engine that walks the Device Feature Header (DFH) linked list in a CSR BAR space, starting at a programmable base offset.
- Issues 64-bit MMIO reads, follows nxt_dfh_offset (bits [39:16]) until eol (bit 40) is set, and emits one record per discovered DFH.
- Sits between the host-side MMIO read master (upstream) and the DFH checker/scoreboard that compares records against the expected FME/PG DFH table (downstream).

Parameters:
- ADDR_W, 20, byte-address width of the walked CSR space.
- MAX_DFH, 16, maximum records before the walk aborts; index width IDX_W = $clog2(MAX_DFH+1).
- TIMEOUT_CYC, 1024, response wait limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a walk in IDLE/DONE/ERR.
- base_addr  in  ADDR_W  first DFH byte offset; sampled on start; bits [2:0] ignored (forced 0).
- rd_req_valid  out  1  MMIO read request valid.
- rd_req_ready  in  1  read master accepts request.
- rd_req_addr  out  ADDR_W  8-byte-aligned read address.
- rd_rsp_valid  in  1  read data valid (no backpressure).
- rd_rsp_data  in  64  read data.
- dfh_valid  out  1  discovered-record valid.
- dfh_ready  in  1  consumer accepts record.
- dfh_addr  out  ADDR_W  address of the record's DFH.
- dfh_data  out  64  raw DFH value.
- dfh_idx  out  IDX_W  0-based record index.
- busy  out  1  walk in progress.
- done  out  1  sticky; walk ended on eol.
- err  out  1  sticky; walk aborted.
- err_code  out  3  0 none, 1 zero offset without eol, 2 address overflow, 3 MAX_DFH exceeded, 4 timeout.
- dfh_count  out  IDX_W  records emitted in the current/last walk.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; cur_addr, idx, count cleared.
- FSM states: IDLE, REQ, WAIT, EMIT, DONE, ERR.
- IDLE/DONE/ERR + start: clear done, err, err_code, dfh_count and idx; cur_addr = {base_addr[ADDR_W-1:3],3'b0}; go to REQ. start in REQ/WAIT/EMIT is ignored.
- REQ: rd_req_valid=1, rd_req_addr=cur_addr held stable until rd_req_ready; handshake -> WAIT.
- WAIT: first rd_rsp_valid captures rd_rsp_data into the record register -> EMIT. rd_rsp_valid outside WAIT is dropped.
- EMIT: dfh_valid=1 with dfh_addr=cur_addr, dfh_data, dfh_idx=idx, all stable until dfh_ready. On the handshake cycle, dfh_count increments, then in priority order:
  - eol=1 -> DONE, done=1.
  - nxt_dfh_offset==0 -> ERR, code 1.
  - cur_addr + offset computed in ADDR_W+1 bits; carry set -> ERR, code 2.
  - idx+1 == MAX_DFH -> ERR, code 3.
  - otherwise cur_addr += offset, idx++, -> REQ.
- The nxt_dfh_offset low 3 bits are added as-is; resulting rd_req_addr is forced 8-byte aligned.
- busy=1 in REQ/WAIT/EMIT. done and err are mutually exclusive and hold until the next start.
- Minimum per-record latency: request handshake to dfh_valid = response latency + 1 cycle. EMIT handshake to next rd_req_valid = 1 cycle.
- Asynchronous reset mid-walk: immediate return to IDLE; no further requests or records. A response arriving after reset is ignored.

Optional Feature:
- DFH_WALKER_TIMEOUT_EN defined: 
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC without rd_rsp_valid -> ERR, code 4, no record emitted.
  - A response on the same cycle as expiry wins (no timeout).
- Not defined: the counter is not built; WAIT holds indefinitely; code 4 is never produced.

Test Plan:
- Chain at 0x0 (offset 0x1000), 0x1000 (offset 0x2000), 0x3000 (eol=1), base 0x0 -> three records idx 0/1/2, addrs 0x0/0x1000/0x3000; done=1, dfh_count=3, err=0.
- Same chain with dfh_ready low 5 cycles per record and rd_req_ready low 3 cycles -> dfh_*/rd_req_addr stable while stalled; identical record stream; no extra reads.
- DFH at 0x40 with offset 0, eol=0 -> one record emitted; then err=1, err_code=1, busy=0.
- MAX_DFH=4, five-entry chain without eol -> four records; err_code=3; fifth address never read.
- DFH_WALKER_TIMEOUT_EN, TIMEOUT_CYC=16, no response -> err_code=4 exactly 16 cycles after entering WAIT; no dfh_valid.
- rst_n asserted while in WAIT after the second record; late rd_rsp_valid -> all outputs 0, FSM IDLE; a new start from base 0x0 reproduces the first record.
